// File: rtl/pd_pkg.sv
// pd_pkg -- vote encoding shared by the Alexander phase-detector cell and the voter.
// Rev 1.0
`default_nettype none

package pd_pkg;

    typedef enum logic [1:0] {
        VOTE_NONE  = 2'b00,
        VOTE_LATE  = 2'b01,
        VOTE_EARLY = 2'b10
    } vote_t;

    // Signed contribution of one vote to the window's net count.
    function automatic logic signed [1:0] vote_step(input vote_t v);
        case (v)
            VOTE_LATE:  vote_step = 2'sd1;
            VOTE_EARLY: vote_step = -2'sd1;
            default:    vote_step = 2'sd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/alexander_pd_cell.sv
// alexander_pd_cell -- holds the previous data sample and classifies each strobe as late/early/none.
// Rev 1.0
`default_nettype none

module alexander_pd_cell
    import pd_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  sym_en,
    input  logic  d_in,
    input  logic  e_in,
    output vote_t vote
);

    logic dp;
    logic prev_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            dp         <= 1'b0;
            prev_valid <= 1'b0;
        end else if (sym_en) begin
            dp         <= d_in;
            prev_valid <= 1'b1;
        end
    end

    // Edge sample matching the new bit means the edge arrived after the transition: clock is late.
    always_comb begin
        vote = VOTE_NONE;
        if (sym_en && prev_valid && (dp != d_in)) begin
            vote = (e_in == d_in) ? VOTE_LATE : VOTE_EARLY;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bbpd_voter.sv
// bbpd_voter -- bang-bang phase detector with windowed majority vote feeding the CDR loop filter.
// Rev 1.0
`default_nettype none

module bbpd_voter
    import pd_pkg::*;
#(
    parameter int VOTE_LEN = 8,
    parameter int THRESH   = 2,
    localparam int NW      = $clog2(VOTE_LEN + 1) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sym_en,
    input  logic          d_in,
    input  logic          e_in,
    output logic          en,
    output logic          R,
    output logic          V,
    output logic [NW-2:0] tcount
);

    localparam int TW = NW - 1;
    localparam int CW = $clog2(VOTE_LEN);

    localparam logic [CW-1:0]        LAST_IDX = CW'(VOTE_LEN - 1);
    localparam logic signed [NW-1:0] THR_POS  = NW'(THRESH);
    localparam logic signed [NW-1:0] THR_NEG  = -NW'(THRESH);

    vote_t                 vote;
    logic [CW-1:0]         win_cnt;
    logic signed [NW-1:0]  net;
    logic [TW-1:0]         trans;

    logic signed [1:0]     step;
    logic signed [NW-1:0]  net_final;
    logic [TW-1:0]         trans_final;
    logic                  is_trans;
    logic                  closing;

    alexander_pd_cell u_cell (
        .clk    (clk),
        .rst    (rst),
        .sym_en (sym_en),
        .d_in   (d_in),
        .e_in   (e_in),
        .vote   (vote)
    );

    // Totals including the current strobe, so the closing strobe's vote lands in its own decision.
    always_comb begin
        step        = vote_step(vote);
        is_trans    = (vote != VOTE_NONE);
        net_final   = net + {{(NW-2){step[1]}}, step};
        trans_final = trans + {{(TW-1){1'b0}}, is_trans};
        closing     = sym_en && (win_cnt == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            win_cnt <= '0;
            net     <= '0;
            trans   <= '0;
            en      <= 1'b0;
            R       <= 1'b0;
            V       <= 1'b0;
            tcount  <= '0;
        end else begin
            en <= closing;
            if (closing) begin
                win_cnt <= '0;
                net     <= '0;
                trans   <= '0;
                R       <= (net_final >= THR_POS);
                V       <= (net_final <= THR_NEG);
                tcount  <= trans_final;
            end else if (sym_en) begin
                win_cnt <= win_cnt + 1'b1;
                net     <= net_final;
                trans   <= trans_final;
            end
        end
    end

endmodule

`default_nettype wire
